game_flow_ctrl: RTL and testbench

- Game-level sequencer that owns the round timer and coin bookkeeping, and decides when the win/loss message overlay is shown.
- Sits between the clock divider (250 Hz tick), the player/coin collision logic and the message renderer.
- The message renderer stays a pure pixel datapath.
- Provides restart, a minimum message hold time and message blinking.

---
 rtl/game_flow_ctrl.sv | 154 +++++++++++++++
 tb/tb_game_flow_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/game_flow_ctrl.sv
// Round sequencer: owns the round timer and coin count, and decides when
// the win/loss overlay is shown, how it blinks, and when a restart is accepted.
module game_flow_ctrl #(
    parameter int NUM_COINS   = 8,
    parameter int TIME_TICKS  = 1000,
    parameter int HOLD_TICKS  = 250,
    parameter int BLINK_TICKS = 125
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       start,
    input  logic       coin_hit,
    output logic [3:0] coins_left,
    output logic [9:0] time_remaining,
    output logic       play_en,
    output logic       msg_valid,
    output logic       msg_sel,
    output logic       msg_on,
    output logic [1:0] state
);

    localparam int HOLD_W  = (HOLD_TICKS < 2) ? 1 : $clog2(HOLD_TICKS + 1);
    localparam int BLINK_W = (BLINK_TICKS < 2) ? 1 : $clog2(BLINK_TICKS);

    localparam logic [3:0]         COINS_INIT = 4'(NUM_COINS);
    localparam logic [9:0]         TIME_INIT  = 10'(TIME_TICKS);
    localparam logic [HOLD_W-1:0]  HOLD_MAX   = HOLD_W'(HOLD_TICKS);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_TICKS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        WIN  = 2'd2,
        LOSE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         coins_q, coins_d;
    logic [9:0]         time_q, time_d;
    logic               play_en_q, play_en_d;
    logic               msg_valid_q, msg_valid_d;
    logic               msg_sel_q, msg_sel_d;
    logic               msg_on_q, msg_on_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [BLINK_W-1:0] blink_q, blink_d;
    logic               start_q, start_d;

    logic               start_rise;
    logic [3:0]         coins_nxt;
    logic [9:0]         time_nxt;

    assign start_rise = start & ~start_q;

    always_comb begin
        state_d     = state_q;
        coins_d     = coins_q;
        time_d      = time_q;
        play_en_d   = play_en_q;
        msg_valid_d = msg_valid_q;
        msg_sel_d   = msg_sel_q;
        msg_on_d    = msg_on_q;
        hold_d      = hold_q;
        blink_d     = blink_q;
        start_d     = start;
        coins_nxt   = coins_q;
        time_nxt    = time_q;

        case (state_q)
            IDLE: begin
                if (start_rise) begin
                    state_d   = PLAY;
                    coins_d   = COINS_INIT;
                    time_d    = TIME_INIT;
                    play_en_d = 1'b1;
                end
            end

            PLAY: begin
                // Both decrements apply in the same clk; exit is decided on post-update values.
                if (coin_hit && coins_q != 4'd0) coins_nxt = coins_q - 4'd1;
                if (tick && time_q != 10'd0)     time_nxt  = time_q - 10'd1;
                coins_d = coins_nxt;
                time_d  = time_nxt;
                if (coins_nxt == 4'd0 || time_nxt == 10'd0) begin
                    state_d     = (coins_nxt == 4'd0) ? WIN : LOSE;
                    msg_sel_d   = (coins_nxt != 4'd0);
                    play_en_d   = 1'b0;
                    msg_valid_d = 1'b1;
                    msg_on_d    = 1'b1;
                    hold_d      = '0;
                    blink_d     = '0;
                end
            end

            default: begin
                if (tick) begin
                    if (hold_q != HOLD_MAX) hold_d = hold_q + HOLD_W'(1);
                    if (blink_q == BLINK_LAST) begin
                        blink_d  = '0;
                        msg_on_d = ~msg_on_q;
                    end else begin
                        blink_d = blink_q + BLINK_W'(1);
                    end
                end
                // Restart only after the minimum hold; msg_sel keeps the last result.
                if (start_rise && hold_q == HOLD_MAX) begin
                    state_d     = PLAY;
                    coins_d     = COINS_INIT;
                    time_d      = TIME_INIT;
                    play_en_d   = 1'b1;
                    msg_valid_d = 1'b0;
                    msg_on_d    = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            coins_q     <= COINS_INIT;
            time_q      <= TIME_INIT;
            play_en_q   <= 1'b0;
            msg_valid_q <= 1'b0;
            msg_sel_q   <= 1'b0;
            msg_on_q    <= 1'b0;
            hold_q      <= '0;
            blink_q     <= '0;
            // A button held through reset must not look like a fresh press.
            start_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            coins_q     <= coins_d;
            time_q      <= time_d;
            play_en_q   <= play_en_d;
            msg_valid_q <= msg_valid_d;
            msg_sel_q   <= msg_sel_d;
            msg_on_q    <= msg_on_d;
            hold_q      <= hold_d;
            blink_q     <= blink_d;
            start_q     <= start_d;
        end
    end

    assign coins_left     = coins_q;
    assign time_remaining = time_q;
    assign play_en        = play_en_q;
    assign msg_valid      = msg_valid_q;
    assign msg_sel        = msg_sel_q;
    assign msg_on         = msg_on_q;
    assign state          = state_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl: expected snapshots are queued as stimulus
// is driven and popped/compared once the DUT has registered the step.
module tb_game_flow_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0, start = 1'b1, coin_hit = 1'b0;
    logic [3:0] coins_left;
    logic [9:0] time_remaining;
    logic       play_en, msg_valid, msg_sel, msg_on;
    logic [1:0] state;

    logic       tick2 = 1'b0, start2 = 1'b0, coin2 = 1'b0;
    logic [3:0] coins2;
    logic [9:0] time2;
    logic       play_en2, msg_valid2, msg_sel2, msg_on2;
    logic [1:0] state2;

    always #5 clk = ~clk;

    game_flow_ctrl u_dut (
        .clk(clk), .rst(rst), .tick(tick), .start(start), .coin_hit(coin_hit),
        .coins_left(coins_left), .time_remaining(time_remaining), .play_en(play_en),
        .msg_valid(msg_valid), .msg_sel(msg_sel), .msg_on(msg_on), .state(state)
    );

    game_flow_ctrl #(.NUM_COINS(1), .TIME_TICKS(4)) u_small (
        .clk(clk), .rst(rst), .tick(tick2), .start(start2), .coin_hit(coin2),
        .coins_left(coins2), .time_remaining(time2), .play_en(play_en2),
        .msg_valid(msg_valid2), .msg_sel(msg_sel2), .msg_on(msg_on2), .state(state2)
    );

    typedef struct packed {
        logic [1:0] st;
        logic [3:0] coins;
        logic [9:0] tm;
        logic       pe;
        logic       mv;
        logic       ms;
        logic       mo;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   toggles = 0;
    logic prev_on;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic push(input logic [1:0] st, input int coins, input int tm,
                        input logic pe, input logic mv, input logic ms, input logic mo);
        exp_t e;
        e.st = st; e.coins = 4'(coins); e.tm = 10'(tm);
        e.pe = pe; e.mv = mv; e.ms = ms; e.mo = mo;
        sb.push_back(e);
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, ".state"},     32'(state),          32'(e.st));
            chk({tag, ".coins"},     32'(coins_left),     32'(e.coins));
            chk({tag, ".time"},      32'(time_remaining), 32'(e.tm));
            chk({tag, ".play_en"},   32'(play_en),        32'(e.pe));
            chk({tag, ".msg_valid"}, 32'(msg_valid),      32'(e.mv));
            chk({tag, ".msg_sel"},   32'(msg_sel),        32'(e.ms));
            chk({tag, ".msg_on"},    32'(msg_on),         32'(e.mo));
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_main();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        cyc();
    endtask

    task automatic coin_main();
        coin_hit = 1'b1;
        cyc();
        coin_hit = 1'b0;
        cyc();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset with the button held.
        repeat (3) cyc();
        push(2'd0, 8, 1000, 0, 0, 0, 0);
        pop_check("reset");
        rst = 1'b0;
        repeat (10) cyc();
        push(2'd0, 8, 1000, 0, 0, 0, 0);
        pop_check("held_start");
        start = 1'b0;
        cyc();
        start = 1'b1;
        push(2'd1, 8, 1000, 1, 0, 0, 0);
        cyc();
        pop_check("start_rise");
        start = 1'b0;
        cyc();

        // Collect all coins with no ticks.
        for (int i = 0; i < 8; i++) begin
            coin_hit = 1'b1;
            push((i == 7) ? 2'd2 : 2'd1, 7 - i, 1000, i != 7, i == 7, 0, i == 7);
            cyc();
            coin_hit = 1'b0;
            pop_check($sformatf("coin%0d", i + 1));
            cyc();
            cyc();
        end
        coin_hit = 1'b1;
        push(2'd2, 0, 1000, 0, 1, 0, 1);
        cyc();
        coin_hit = 1'b0;
        pop_check("coin_in_win");
        cyc();

        // Hold and blink in WIN.
        prev_on = msg_on;
        for (int k = 1; k <= 250; k++) begin
            tick_main();
            if (msg_on !== prev_on) toggles++;
            prev_on = msg_on;
            if (k == 124 || k == 125 || k == 249 || k == 250) begin
                push(2'd2, 0, 1000, 0, 1, 0, (k == 124 || k == 250) ? 1'b1 : 1'b0);
                pop_check($sformatf("win_tick%0d", k));
            end
            if (k == 100 || k == 249) begin
                start = 1'b1;
                push(2'd2, 0, 1000, 0, 1, 0, (k == 100) ? 1'b1 : 1'b0);
                cyc();
                pop_check($sformatf("early_start%0d", k));
                start = 1'b0;
                cyc();
            end
        end
        chk("blink_toggles", 32'(toggles), 32'd2);
        start = 1'b1;
        push(2'd1, 8, 1000, 1, 0, 0, 0);
        cyc();
        pop_check("restart_win");
        start = 1'b0;
        cyc();

        // Three coins, then run the timer out.
        for (int i = 0; i < 3; i++) coin_main();
        for (int k = 1; k <= 1000; k++) begin
            tick = 1'b1;
            if (k == 1 || k == 999)
                push(2'd1, 5, 1000 - k, 1, 0, 0, 0);
            else if (k == 1000)
                push(2'd3, 5, 0, 0, 1, 1, 1);
            cyc();
            tick = 1'b0;
            if (k == 1 || k >= 999) pop_check($sformatf("timer%0d", k));
            cyc();
        end
        tick = 1'b1;
        push(2'd3, 5, 0, 0, 1, 1, 1);
        cyc();
        tick = 1'b0;
        pop_check("tick_in_lose");
        coin_hit = 1'b1;
        push(2'd3, 5, 0, 0, 1, 1, 1);
        cyc();
        coin_hit = 1'b0;
        pop_check("coin_in_lose");

        // Restart from LOSE keeps msg_sel.
        for (int k = 0; k < 260; k++) tick_main();
        start = 1'b1;
        push(2'd1, 8, 1000, 1, 0, 1, 0);
        cyc();
        pop_check("restart_lose");
        start = 1'b0;
        cyc();

        // Simultaneous tick and coin, then reset mid-round.
        tick = 1'b1;
        coin_hit = 1'b1;
        push(2'd1, 7, 999, 1, 0, 1, 0);
        cyc();
        tick = 1'b0;
        coin_hit = 1'b0;
        pop_check("tick_and_coin");
        for (int i = 0; i < 4; i++) coin_main();
        for (int k = 0; k < 399; k++) tick_main();
        push(2'd1, 3, 600, 1, 0, 1, 0);
        pop_check("mid_round");
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        push(2'd0, 8, 1000, 0, 0, 0, 0);
        pop_check("async_rst");
        cyc();
        rst = 1'b0;
        cyc();

        // Small instance: last coin and timer expiry together.
        start2 = 1'b1;
        cyc();
        start2 = 1'b0;
        chk("small_start.state", 32'(state2), 32'd1);
        chk("small_start.time",  32'(time2),  32'd4);
        for (int k = 0; k < 3; k++) begin
            tick2 = 1'b1;
            cyc();
            tick2 = 1'b0;
            cyc();
        end
        chk("small_3ticks.time",  32'(time2),  32'd1);
        chk("small_3ticks.state", 32'(state2), 32'd1);
        tick2 = 1'b1;
        coin2 = 1'b1;
        cyc();
        tick2 = 1'b0;
        coin2 = 1'b0;
        chk("small_tie.state",   32'(state2),   32'd2);
        chk("small_tie.time",    32'(time2),    32'd0);
        chk("small_tie.coins",   32'(coins2),   32'd0);
        chk("small_tie.msg_sel", 32'(msg_sel2), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
